lbp: RTL and testbench

LBP -- requirements
Module: lbp

---
 rtl/lbp_if.sv | 22 ++
 rtl/lbp.sv | 252 +++++++++++++++++++++++++
 tb/tb_lbp.sv | 234 +++++++++++++++++++++++
 3 files changed

// File: rtl/lbp_if.sv
// Bus bundle for the LBP block: gray-image read port, LBP-result write port and status.
// The block drives the master side; the memories/environment sit on the slave side.
interface lbp_if;
    logic        gray_ready;
    logic        gray_req;
    logic [13:0] gray_addr;
    logic [7:0]  gray_data;
    logic        lbp_valid;
    logic [13:0] lbp_addr;
    logic [7:0]  lbp_data;
    logic        finish;

    modport master (
        input  gray_ready, gray_data,
        output gray_req, gray_addr, lbp_valid, lbp_addr, lbp_data, finish
    );

    modport slave (
        output gray_ready, gray_data,
        input  gray_req, gray_addr, lbp_valid, lbp_addr, lbp_data, finish
    );
endinterface

// File: rtl/lbp.sv
// 3x3 local-binary-pattern engine: sliding window over a row-major image, one write per pixel.
// Optional macro LBP_BORDER_WRITE_EN also writes 0x00 to every border pixel in the same pass.
module lbp #(
    parameter int IMG_W = 128,
    parameter int IMG_H = 128
) (
    input  logic  clk,
    input  logic  reset,
    lbp_if.master bus
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        SHIFT = 3'd2,
        CALC  = 3'd3,
        WRITE = 3'd4,
        DONE  = 3'd5
    } state_t;

`ifdef LBP_BORDER_WRITE_EN
    localparam logic [6:0] EDGE_ROW = 7'(IMG_H - 1);
    localparam logic [6:0] EDGE_COL = 7'(IMG_W - 1);
`else
    localparam logic [6:0] LAST_ROW = 7'(IMG_H - 2);
    localparam logic [6:0] LAST_COL = 7'(IMG_W - 2);
`endif

    state_t state_r, state_s;
    logic [6:0] row_r, row_s, col_r, col_s;
    logic [1:0] i_r, i_s, j_r, j_s;
    logic [2:0][2:0][7:0] win_r;
    logic [7:0] code_s;

    logic [6:0] step_row_s, step_col_s, rd_row_s, rd_col_s;
    logic       last_px_s;
`ifdef LBP_BORDER_WRITE_EN
    logic       step_border_s;
`endif

    logic        gray_req_r, gray_req_s;
    logic [13:0] gray_addr_r, gray_addr_s;
    logic        lbp_valid_r, lbp_valid_s;
    logic [13:0] lbp_addr_r, lbp_addr_s;
    logic [7:0]  lbp_data_r, lbp_data_s;
    logic        finish_r, finish_s;

    // Bit k is set when neighbour k is not darker than the centre (ties give 1).
    function automatic logic [7:0] lbp_code(input logic [2:0][2:0][7:0] w);
        logic [7:0] gc;
        logic [7:0] code;
        gc      = w[1][1];
        code[0] = (w[0][0] >= gc);
        code[1] = (w[0][1] >= gc);
        code[2] = (w[0][2] >= gc);
        code[3] = (w[1][0] >= gc);
        code[4] = (w[1][2] >= gc);
        code[5] = (w[2][0] >= gc);
        code[6] = (w[2][1] >= gc);
        code[7] = (w[2][2] >= gc);
        return code;
    endfunction

    assign code_s = lbp_code(win_r);

    // Next write position in row-major order and whether the current one is the last.
    always_comb begin
        step_row_s = row_r;
        step_col_s = col_r;
`ifdef LBP_BORDER_WRITE_EN
        if (col_r == EDGE_COL) begin
            step_row_s = row_r + 7'd1;
            step_col_s = 7'd0;
        end else begin
            step_col_s = col_r + 7'd1;
        end
        last_px_s     = (row_r == EDGE_ROW) && (col_r == EDGE_COL);
        step_border_s = (step_row_s == 7'd0) || (step_row_s == EDGE_ROW) ||
                        (step_col_s == 7'd0) || (step_col_s == EDGE_COL);
`else
        if (col_r == LAST_COL) begin
            step_row_s = row_r + 7'd1;
            step_col_s = 7'd1;
        end else begin
            step_col_s = col_r + 7'd1;
        end
        last_px_s = (row_r == LAST_ROW) && (col_r == LAST_COL);
`endif
    end

    // State, position and read-counter register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= IDLE;
            row_r   <= 7'd0;
            col_r   <= 7'd0;
            i_r     <= 2'd0;
            j_r     <= 2'd0;
        end else begin
            state_r <= state_s;
            row_r   <= row_s;
            col_r   <= col_s;
            i_r     <= i_s;
            j_r     <= j_s;
        end
    end

    // Next-state logic; i walks the rows of a window column, j the columns during LOAD.
    always_comb begin
        state_s = state_r;
        row_s   = row_r;
        col_s   = col_r;
        i_s     = i_r;
        j_s     = j_r;
        case (state_r)
            IDLE: begin
                if (bus.gray_ready) begin
                    i_s = 2'd0;
                    j_s = 2'd0;
`ifdef LBP_BORDER_WRITE_EN
                    row_s   = 7'd0;
                    col_s   = 7'd0;
                    state_s = WRITE;
`else
                    row_s   = 7'd1;
                    col_s   = 7'd1;
                    state_s = LOAD;
`endif
                end else begin
                    state_s = IDLE;
                end
            end
            LOAD: begin
                if (i_r == 2'd2) begin
                    i_s = 2'd0;
                    if (j_r == 2'd2) begin
                        state_s = CALC;
                    end else begin
                        j_s = j_r + 2'd1;
                    end
                end else begin
                    i_s = i_r + 2'd1;
                end
            end
            SHIFT: begin
                if (i_r == 2'd2) begin
                    i_s     = 2'd0;
                    state_s = CALC;
                end else begin
                    i_s = i_r + 2'd1;
                end
            end
            CALC: state_s = WRITE;
            WRITE: begin
                if (last_px_s) begin
                    state_s = DONE;
                end else begin
                    row_s = step_row_s;
                    col_s = step_col_s;
                    i_s   = 2'd0;
`ifdef LBP_BORDER_WRITE_EN
                    if (step_border_s) begin
                        j_s     = 2'd0;
                        state_s = WRITE;
                    end else if (step_col_s == 7'd1) begin
                        j_s     = 2'd0;
                        state_s = LOAD;
                    end else begin
                        j_s     = 2'd2;
                        state_s = SHIFT;
                    end
`else
                    if (step_col_s == 7'd1) begin
                        j_s     = 2'd0;
                        state_s = LOAD;
                    end else begin
                        j_s     = 2'd2;
                        state_s = SHIFT;
                    end
`endif
                end
            end
            DONE:    state_s = DONE;
            default: state_s = IDLE;
        endcase
    end

    // Output decode from the upcoming state so every port comes straight from a flop.
    always_comb begin
        rd_row_s = row_s + {5'd0, i_s} - 7'd1;
        rd_col_s = col_s + {5'd0, j_s} - 7'd1;
        if ((state_s == LOAD) || (state_s == SHIFT)) begin
            gray_req_s  = 1'b1;
            gray_addr_s = {rd_row_s, rd_col_s};
        end else begin
            gray_req_s  = 1'b0;
            gray_addr_s = 14'd0;
        end
        if (state_s == WRITE) begin
            lbp_valid_s = 1'b1;
            lbp_addr_s  = {row_s, col_s};
            lbp_data_s  = (state_r == CALC) ? code_s : 8'h00;
        end else begin
            lbp_valid_s = 1'b0;
            lbp_addr_s  = 14'd0;
            lbp_data_s  = 8'h00;
        end
        finish_s = (state_s == DONE);
    end

    // Output registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            gray_req_r  <= 1'b0;
            gray_addr_r <= 14'd0;
            lbp_valid_r <= 1'b0;
            lbp_addr_r  <= 14'd0;
            lbp_data_r  <= 8'h00;
            finish_r    <= 1'b0;
        end else begin
            gray_req_r  <= gray_req_s;
            gray_addr_r <= gray_addr_s;
            lbp_valid_r <= lbp_valid_s;
            lbp_addr_r  <= lbp_addr_s;
            lbp_data_r  <= lbp_data_s;
            finish_r    <= finish_s;
        end
    end

    // Window capture: each new column enters on the right, older columns move left.
    always_ff @(posedge clk) begin
        if (reset) begin
            win_r <= '0;
        end else if ((state_r == LOAD) || (state_r == SHIFT)) begin
            if (i_r == 2'd0) begin
                for (int k = 0; k < 3; k++) begin
                    win_r[k][0] <= win_r[k][1];
                    win_r[k][1] <= win_r[k][2];
                end
            end
            win_r[i_r][2] <= bus.gray_data;
        end
    end

    assign bus.gray_req  = gray_req_r;
    assign bus.gray_addr = gray_addr_r;
    assign bus.lbp_valid = lbp_valid_r;
    assign bus.lbp_addr  = lbp_addr_r;
    assign bus.lbp_data  = lbp_data_r;
    assign bus.finish    = finish_r;

endmodule

// File: tb/tb_lbp.sv
// Self-checking bench for lbp on a 16x16 image: golden writes queued per frame, popped per DUT write.
module tb_lbp;
    localparam int W = 16;
    localparam int H = 16;
    localparam int BUDGET = 20000;
    localparam logic [7:0] DIP_EXP [9] = '{8'h7F, 8'hBF, 8'hDF, 8'hEF, 8'hFF, 8'hF7, 8'hFB, 8'hFD, 8'hFE};

    typedef struct packed {
        logic [13:0] addr;
        logic [7:0]  data;
    } wr_t;

    logic clk = 1'b0;
    logic reset;
    logic ready;
    logic [7:0] gray_mem [0:16383];
    logic [7:0] res_mem  [0:16383];
    wr_t exp_q [$];
    int  exp_total;
    int  vectors = 0;
    int  miscompares = 0;

    lbp_if bus();
    assign bus.gray_ready = ready;
    assign bus.gray_data  = bus.gray_req ? gray_mem[bus.gray_addr] : 8'hA5;

    lbp #(.IMG_W(W), .IMG_H(H)) dut (.clk(clk), .reset(reset), .bus(bus));

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        assert (got === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [13:0] ad(input int r, input int c);
        return {7'(r), 7'(c)};
    endfunction

    function automatic bit is_border(input int r, input int c);
        return (r == 0) || (c == 0) || (r == H - 1) || (c == W - 1);
    endfunction

    function automatic logic [7:0] ref_code(input int r, input int c);
        int dr [8];
        int dc [8];
        logic [7:0] gc;
        logic [7:0] code;
        dr = '{-1, -1, -1, 0, 0, 1, 1, 1};
        dc = '{-1, 0, 1, -1, 1, -1, 0, 1};
        gc = gray_mem[ad(r, c)];
        for (int k = 0; k < 8; k++) code[k] = (gray_mem[ad(r + dr[k], c + dc[k])] >= gc);
        return code;
    endfunction

    task automatic fill(input int mode);
        for (int r = 0; r < 128; r++) begin
            for (int c = 0; c < 128; c++) begin
                case (mode)
                    0:       gray_mem[ad(r, c)] = 8'h00;
                    1:       gray_mem[ad(r, c)] = 8'h63;
                    2:       gray_mem[ad(r, c)] = 8'(c);
                    3:       gray_mem[ad(r, c)] = 8'(r);
                    default: gray_mem[ad(r, c)] = 8'($urandom_range(0, 3) * 60);
                endcase
            end
        end
    endtask

    task automatic build_expected();
        exp_q.delete();
        for (int i = 0; i < 16384; i++) res_mem[i] = 8'h00;
        for (int r = 0; r < H; r++) begin
            for (int c = 0; c < W; c++) begin
                if (!is_border(r, c)) begin
                    exp_q.push_back('{ad(r, c), ref_code(r, c)});
                end else begin
`ifdef LBP_BORDER_WRITE_EN
                    exp_q.push_back('{ad(r, c), 8'h00});
`endif
                end
            end
        end
        exp_total = exp_q.size();
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        ready = 1'b0;
        @(negedge clk);
        chk("rst_gray_req", 32'(bus.gray_req), 32'd0);
        chk("rst_gray_addr", 32'(bus.gray_addr), 32'd0);
        chk("rst_lbp_valid", 32'(bus.lbp_valid), 32'd0);
        chk("rst_lbp_addr", 32'(bus.lbp_addr), 32'd0);
        chk("rst_lbp_data", 32'(bus.lbp_data), 32'd0);
        chk("rst_finish", 32'(bus.finish), 32'd0);
        reset = 1'b0;
    endtask

    // Runs one frame; abort_after > 0 stops watching after that many writes.
    task automatic run_frame(input int abort_after);
        int  cyc = 0;
        int  nw = 0;
        int  overlap = 0;
        int  extra = 0;
        bit  done = 1'b0;
        bit  aborted = 1'b0;
        wr_t e;
        ready = 1'b1;
        while (!done && cyc < BUDGET) begin
            @(negedge clk);
            cyc++;
            if (cyc == 20) ready = 1'b0;
            if (bus.lbp_valid === 1'b1) begin
                if (bus.gray_req === 1'b1 || bus.finish === 1'b1) overlap++;
                if (exp_q.size() == 0) begin
                    extra++;
                end else begin
                    e = exp_q.pop_front();
                    chk("wr_addr", 32'(bus.lbp_addr), 32'(e.addr));
                    chk("wr_data", 32'(bus.lbp_data), 32'(e.data));
                end
                res_mem[bus.lbp_addr] = bus.lbp_data;
                nw++;
                if (abort_after > 0 && nw == abort_after) begin
                    done = 1'b1;
                    aborted = 1'b1;
                end
            end
            if (bus.finish === 1'b1) done = 1'b1;
        end
        chk("extra_writes", 32'(extra), 32'd0);
        chk("strobe_overlap", 32'(overlap), 32'd0);
        if (aborted) begin
            chk("abort_no_finish", 32'(bus.finish), 32'd0);
        end else begin
            chk("finish", 32'(bus.finish), 32'd1);
            chk("pending_writes", 32'(exp_q.size()), 32'd0);
            chk("write_count", 32'(nw), 32'(exp_total));
            repeat (5) @(negedge clk);
            chk("finish_hold", 32'(bus.finish), 32'd1);
            chk("valid_after_finish", 32'(bus.lbp_valid), 32'd0);
        end
    endtask

    task automatic check_borders();
        int bad = 0;
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++)
                if (is_border(r, c) && res_mem[ad(r, c)] !== 8'h00) bad++;
        chk("border_zero", 32'(bad), 32'd0);
    endtask

    task automatic check_interior(input string tag, input logic [7:0] val);
        int bad = 0;
        for (int r = 1; r < H - 1; r++)
            for (int c = 1; c < W - 1; c++)
                if (res_mem[ad(r, c)] !== val) bad++;
        chk(tag, 32'(bad), 32'd0);
    endtask

    initial begin
        int idle_act;
        reset = 1'b1;
        ready = 1'b0;
        repeat (2) @(negedge clk);
        do_reset();

        // gray_ready held low: nothing may move.
        idle_act = 0;
        repeat (50) begin
            @(negedge clk);
            if (bus.gray_req !== 1'b0 || bus.lbp_valid !== 1'b0 || bus.finish !== 1'b0) idle_act++;
        end
        chk("idle_quiet", 32'(idle_act), 32'd0);

        // Flat black image.
        fill(0);
        build_expected();
        run_frame(0);
        check_interior("flat_ff", 8'hFF);
        check_borders();

        // Bright centre: everything else ties.
        do_reset();
        fill(1);
        gray_mem[ad(5, 5)] = 8'h64;
        build_expected();
        run_frame(0);
        chk("peak_centre", 32'(res_mem[ad(5, 5)]), 32'h00);
        chk("peak_nbr_tie", 32'(res_mem[ad(4, 4)]), 32'hFF);
        chk("peak_far", 32'(res_mem[ad(10, 10)]), 32'hFF);

        // Dark centre: each neighbour loses exactly its bit toward (5,5).
        do_reset();
        fill(1);
        gray_mem[ad(5, 5)] = 8'h62;
        build_expected();
        run_frame(0);
        for (int k = 0; k < 9; k++)
            chk("dip_bitmap", 32'(res_mem[ad(4 + k / 3, 4 + k % 3)]), 32'(DIP_EXP[k]));

        // Column and row ramps.
        do_reset();
        fill(2);
        build_expected();
        run_frame(0);
        check_interior("col_ramp_d6", 8'hD6);
        check_borders();

        do_reset();
        fill(3);
        build_expected();
        run_frame(0);
        check_interior("row_ramp_f8", 8'hF8);

        // Random image, aborted mid-frame by reset, then rerun from the top.
        do_reset();
        fill(4);
        build_expected();
        run_frame(60);
        do_reset();
        build_expected();
        run_frame(0);
        check_borders();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
